snake_motion_sched: RTL and testbench

Per-frame motion scheduler for both snakes. It decodes the two USB keycode bytes into direction requests: WASD drives snake 1 and the arrow keys drive snake 2. It rejects 180° reversals, paces movement with a shared step divider, and sequences a knockback episode after an obstacle/body hit. Its outputs are the signed per-frame X/Y increments and 2-bit direction codes consumed by the snake position registers and the collision logic.

---
 rtl/snake_pkg.sv | 87 ++++++++
 rtl/snake_motion_sched_if.sv | 34 +++
 rtl/snake_dir_fsm.sv | 137 +++++++++++++
 rtl/snake_motion_sched.sv | 90 +++++++++
 tb/tb_snake_motion_sched.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared types, key constants and motion helper for the snake motion scheduler.
// Exports: dir_t, state_t, motion_t, key_req_t, keycode constants, MW,
//          motion_vec(), opposite(), decode_wasd(), decode_arrow().
package snake_pkg;

    localparam int unsigned MW = 10;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        LEFT  = 2'd1,
        DOWN  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        KNOCK = 2'd2
    } state_t;

    typedef struct packed {
        logic [MW-1:0] x;
        logic [MW-1:0] y;
    } motion_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_req_t;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;

    localparam logic [MW-1:0] ZERO_M = '0;

    // Signed {x,y} increment of magnitude mag along heading d (up = -Y, left = -X).
    function automatic motion_t motion_vec(dir_t d, logic [MW-1:0] mag);
        motion_t m;
        m = '0;
        case (d)
            UP:      m.y = ZERO_M - mag;
            LEFT:    m.x = ZERO_M - mag;
            DOWN:    m.y = mag;
            default: m.x = mag;
        endcase
        return m;
    endfunction

    function automatic dir_t opposite(dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    function automatic key_req_t decode_wasd(logic [7:0] k);
        key_req_t r;
        r.valid = 1'b1;
        r.dir   = UP;
        case (k)
            KEY_W:   r.dir = UP;
            KEY_A:   r.dir = LEFT;
            KEY_S:   r.dir = DOWN;
            KEY_D:   r.dir = RIGHT;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

    function automatic key_req_t decode_arrow(logic [7:0] k);
        key_req_t r;
        r.valid = 1'b1;
        r.dir   = UP;
        case (k)
            KEY_UP:    r.dir = UP;
            KEY_LEFT:  r.dir = LEFT;
            KEY_DOWN:  r.dir = DOWN;
            KEY_RIGHT: r.dir = RIGHT;
            default:   r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_motion_sched_if.sv
// Bus between game logic and the motion scheduler.
// Inputs to the scheduler: run, keycode, hit1, hit2.
// Outputs: dir1/2, x_motion1/2, y_motion1/2, moving1/2, knock1/2.
interface snake_motion_sched_if;
    import snake_pkg::*;

    logic          run;
    logic [15:0]   keycode;
    logic          hit1;
    logic          hit2;
    logic [1:0]    dir1;
    logic [1:0]    dir2;
    logic [MW-1:0] x_motion1;
    logic [MW-1:0] y_motion1;
    logic [MW-1:0] x_motion2;
    logic [MW-1:0] y_motion2;
    logic          moving1;
    logic          moving2;
    logic          knock1;
    logic          knock2;

    modport master (
        output run, keycode, hit1, hit2,
        input  dir1, dir2, x_motion1, y_motion1, x_motion2, y_motion2,
               moving1, moving2, knock1, knock2
    );

    modport slave (
        input  run, keycode, hit1, hit2,
        output dir1, dir2, x_motion1, y_motion1, x_motion2, y_motion2,
               moving1, moving2, knock1, knock2
    );

endinterface

// File: rtl/snake_dir_fsm.sv
// Per-snake heading FSM (IDLE/MOVE/KNOCK) with pending request, knock counter
// and hit edge detector.
// Ports: frame_clk, Reset (async active-low), run, req_valid/req_dir (decoded
//        key), step_tick, hit (level); outputs dir, x_motion, y_motion,
//        moving, knock (all registered).
module snake_dir_fsm
    import snake_pkg::*;
#(
    parameter int unsigned SPEED        = 1,
    parameter int unsigned KNOCK_FRAMES = 8,
    parameter int unsigned KNOCK_SPEED  = 2
) (
    input  logic          frame_clk,
    input  logic          Reset,
    input  logic          run,
    input  logic          req_valid,
    input  dir_t          req_dir,
    input  logic          step_tick,
    input  logic          hit,
    output dir_t          dir,
    output logic [MW-1:0] x_motion,
    output logic [MW-1:0] y_motion,
    output logic          moving,
    output logic          knock
);

    localparam int unsigned   KW         = (KNOCK_FRAMES > 1) ? $clog2(KNOCK_FRAMES) : 1;
    localparam logic [KW-1:0] KNOCK_LOAD = KW'(KNOCK_FRAMES - 1);
    localparam logic [MW-1:0] SPEED_M    = MW'(SPEED);
    localparam logic [MW-1:0] KNOCK_M    = MW'(KNOCK_SPEED);

    state_t        state, state_n;
    dir_t          dir_n;
    logic          pend_valid, pend_valid_n;
    dir_t          pend_dir, pend_dir_n;
    logic [KW-1:0] knock_cnt, knock_cnt_n;
    logic          hit_q;
    logic          hit_rise;
    logic          eff_valid;
    dir_t          eff_dir;
    motion_t       mot_n;
    logic          moving_n, knock_n;

    assign hit_rise = hit & ~hit_q;

    // Next-state and next-output decision for this frame.
    always_comb begin
        state_n      = state;
        dir_n        = dir;
        pend_valid_n = pend_valid;
        pend_dir_n   = pend_dir;
        knock_cnt_n  = knock_cnt;
        mot_n        = '0;
        eff_valid    = pend_valid;
        eff_dir      = pend_dir;

        if (run) begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state_n = MOVE;
                        dir_n   = req_dir;
                    end
                end
                MOVE: begin
                    if (hit_rise) begin
                        state_n      = KNOCK;
                        knock_cnt_n  = KNOCK_LOAD;
                        pend_valid_n = 1'b0;
                        mot_n        = motion_vec(opposite(dir), KNOCK_M);
                    end else begin
                        // Newest request overwrites pending; reversal is judged at the step.
                        if (req_valid) begin
                            eff_valid = 1'b1;
                            eff_dir   = req_dir;
                        end
                        pend_valid_n = eff_valid;
                        pend_dir_n   = eff_dir;
                        if (step_tick) begin
                            if (eff_valid && (eff_dir != opposite(dir))) begin
                                dir_n = eff_dir;
                            end
                            pend_valid_n = 1'b0;
                            mot_n        = motion_vec(dir_n, SPEED_M);
                        end
                    end
                end
                KNOCK: begin
                    if (hit_rise) begin
                        knock_cnt_n = KNOCK_LOAD;
                        mot_n       = motion_vec(opposite(dir), KNOCK_M);
                    end else if (knock_cnt == '0) begin
                        state_n      = MOVE;
                        pend_valid_n = 1'b0;
                    end else begin
                        knock_cnt_n = knock_cnt - KW'(1);
                        mot_n       = motion_vec(opposite(dir), KNOCK_M);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        moving_n = (state_n == MOVE);
        knock_n  = (state_n == KNOCK);
    end

    // State and registered outputs; hit_q tracks the level even while frozen.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            dir        <= UP;
            pend_valid <= 1'b0;
            pend_dir   <= UP;
            knock_cnt  <= '0;
            hit_q      <= 1'b0;
            x_motion   <= '0;
            y_motion   <= '0;
            moving     <= 1'b0;
            knock      <= 1'b0;
        end else begin
            state      <= state_n;
            dir        <= dir_n;
            pend_valid <= pend_valid_n;
            pend_dir   <= pend_dir_n;
            knock_cnt  <= knock_cnt_n;
            hit_q      <= hit;
            x_motion   <= mot_n.x;
            y_motion   <= mot_n.y;
            moving     <= moving_n;
            knock      <= knock_n;
        end
    end

endmodule

// File: rtl/snake_motion_sched.sv
// Motion scheduler for both snakes: key decode, shared step divider and two
// heading FSMs.
// Ports: frame_clk, Reset (async active-low), bus (slave side of
//        snake_motion_sched_if carrying run/keycode/hits in, headings and
//        per-frame increments out).
module snake_motion_sched
    import snake_pkg::*;
#(
    parameter int unsigned STEP_DIV     = 2,
    parameter int unsigned SPEED        = 1,
    parameter int unsigned KNOCK_FRAMES = 8,
    parameter int unsigned KNOCK_SPEED  = 2
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    snake_motion_sched_if.slave   bus
);

    localparam int unsigned   SW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

    logic [SW-1:0] step_cnt;
    logic          step_tick;
    key_req_t      lo1, hi1, req1;
    key_req_t      lo2, hi2, req2;
    dir_t          dir1, dir2;

    // Key decode: lower byte has priority per snake.
    always_comb begin
        lo1  = decode_wasd(bus.keycode[7:0]);
        hi1  = decode_wasd(bus.keycode[15:8]);
        lo2  = decode_arrow(bus.keycode[7:0]);
        hi2  = decode_arrow(bus.keycode[15:8]);
        req1 = lo1.valid ? lo1 : hi1;
        req2 = lo2.valid ? lo2 : hi2;
    end

    // Shared step divider, frozen while not running.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            step_cnt <= '0;
        end else if (bus.run) begin
            step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + SW'(1);
        end
    end

    assign step_tick = bus.run && (step_cnt == STEP_LAST);

    snake_dir_fsm #(
        .SPEED        (SPEED),
        .KNOCK_FRAMES (KNOCK_FRAMES),
        .KNOCK_SPEED  (KNOCK_SPEED)
    ) u_snake1 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .run       (bus.run),
        .req_valid (req1.valid),
        .req_dir   (req1.dir),
        .step_tick (step_tick),
        .hit       (bus.hit1),
        .dir       (dir1),
        .x_motion  (bus.x_motion1),
        .y_motion  (bus.y_motion1),
        .moving    (bus.moving1),
        .knock     (bus.knock1)
    );

    snake_dir_fsm #(
        .SPEED        (SPEED),
        .KNOCK_FRAMES (KNOCK_FRAMES),
        .KNOCK_SPEED  (KNOCK_SPEED)
    ) u_snake2 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .run       (bus.run),
        .req_valid (req2.valid),
        .req_dir   (req2.dir),
        .step_tick (step_tick),
        .hit       (bus.hit2),
        .dir       (dir2),
        .x_motion  (bus.x_motion2),
        .y_motion  (bus.y_motion2),
        .moving    (bus.moving2),
        .knock     (bus.knock2)
    );

    assign bus.dir1 = dir1;
    assign bus.dir2 = dir2;

endmodule

// File: tb/tb_snake_motion_sched.sv
// Directed bench for snake_motion_sched with default parameters
// (STEP_DIV=2, SPEED=1, KNOCK_FRAMES=8, KNOCK_SPEED=2).
module tb_snake_motion_sched;

    logic frame_clk;
    logic Reset;
    int   checks;
    int   errors;

    snake_motion_sched_if sif ();

    snake_motion_sched dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (sif)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // One frame: outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Two frames of reset; step counter restarts so even frames after release are steps.
    task automatic do_reset();
        Reset       = 1'b0;
        sif.run     = 1'b1;
        sif.keycode = 16'h0000;
        sif.hit1    = 1'b0;
        sif.hit2    = 1'b0;
        repeat (2) tick();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset       = 1'b0;
        sif.run     = 1'b1;
        sif.keycode = 16'h0007;
        sif.hit1    = 1'b0;
        sif.hit2    = 1'b0;
        repeat (2) tick();
        checks++;
        if ({sif.dir1, sif.dir2} !== 4'h0) begin
            errors++; $display("FAIL reset_dir got %h exp 0", {sif.dir1, sif.dir2});
        end
        checks++;
        if ({sif.x_motion1, sif.y_motion1, sif.x_motion2, sif.y_motion2} !== 40'h0) begin
            errors++; $display("FAIL reset_motion got %h exp 0",
                               {sif.x_motion1, sif.y_motion1, sif.x_motion2, sif.y_motion2});
        end
        checks++;
        if ({sif.moving1, sif.moving2, sif.knock1, sif.knock2} !== 4'h0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000",
                               {sif.moving1, sif.moving2, sif.knock1, sif.knock2});
        end
        sif.keycode = 16'h0000;
        Reset = 1'b1;
        tick();
        checks++;
        if ({sif.moving1, sif.moving2, sif.knock1, sif.knock2} !== 4'h0) begin
            errors++; $display("FAIL idle_flags got %b exp 0000",
                               {sif.moving1, sif.moving2, sif.knock1, sif.knock2});
        end
        checks++;
        if ({sif.x_motion1, sif.y_motion1} !== 20'h0) begin
            errors++; $display("FAIL idle_motion got %h exp 0", {sif.x_motion1, sif.y_motion1});
        end
    endtask

    task automatic test_move();
        logic [9:0] exp_x;
        do_reset();
        sif.keycode = 16'h0007;
        tick();
        checks++;
        if (sif.dir1 !== 2'b11 || sif.moving1 !== 1'b1) begin
            errors++; $display("FAIL move_start got dir %b mv %b exp dir 11 mv 1", sif.dir1, sif.moving1);
        end
        checks++;
        if (sif.x_motion1 !== 10'h000) begin
            errors++; $display("FAIL move_first_x got %h exp 000", sif.x_motion1);
        end
        sif.keycode = 16'h0000;
        for (int f = 2; f <= 7; f++) begin
            tick();
            exp_x = (f % 2 == 0) ? 10'h001 : 10'h000;
            checks++;
            if (sif.x_motion1 !== exp_x || sif.y_motion1 !== 10'h000) begin
                errors++; $display("FAIL move_step f%0d got x %h y %h exp x %h y 000",
                                   f, sif.x_motion1, sif.y_motion1, exp_x);
            end
            checks++;
            if (sif.moving2 !== 1'b0 || sif.x_motion2 !== 10'h000 || sif.y_motion2 !== 10'h000) begin
                errors++; $display("FAIL snake2_idle f%0d got mv %b x %h y %h exp 0",
                                   f, sif.moving2, sif.x_motion2, sif.y_motion2);
            end
        end
    endtask

    task automatic test_reversal();
        do_reset();
        sif.keycode = 16'h0007;
        tick();                         // E1: MOVE right
        sif.keycode = 16'h0004;
        tick();                         // E2 step: reversal rejected
        checks++;
        if (sif.dir1 !== 2'b11 || sif.x_motion1 !== 10'h001) begin
            errors++; $display("FAIL rev_direct got dir %b x %h exp dir 11 x 001", sif.dir1, sif.x_motion1);
        end
        sif.keycode = 16'h0000;
        tick();                         // E3
        tick();                         // E4 step
        sif.keycode = 16'h001A;
        tick();                         // E5: up pending
        checks++;
        if (sif.dir1 !== 2'b11) begin
            errors++; $display("FAIL rev_pending_early got %b exp 11", sif.dir1);
        end
        sif.keycode = 16'h0004;
        tick();                         // E6 step: left overwrote up, rejected
        checks++;
        if (sif.dir1 !== 2'b11 || sif.x_motion1 !== 10'h001 || sif.y_motion1 !== 10'h000) begin
            errors++; $display("FAIL rev_overwrite got dir %b x %h y %h exp dir 11 x 001 y 000",
                               sif.dir1, sif.x_motion1, sif.y_motion1);
        end
        sif.keycode = 16'h001A;
        tick();                         // E7: up pending
        sif.keycode = 16'h0000;
        tick();                         // E8 step: turn up
        checks++;
        if (sif.dir1 !== 2'b00 || sif.y_motion1 !== 10'h3FF || sif.x_motion1 !== 10'h000) begin
            errors++; $display("FAIL turn_up got dir %b x %h y %h exp dir 00 x 000 y 3ff",
                               sif.dir1, sif.x_motion1, sif.y_motion1);
        end
    endtask

    task automatic test_dual_decode();
        do_reset();
        sif.keycode = 16'h5216;
        tick();                         // E1
        checks++;
        if (sif.dir1 !== 2'b10 || sif.dir2 !== 2'b00 || sif.moving1 !== 1'b1 || sif.moving2 !== 1'b1) begin
            errors++; $display("FAIL dual_start got d1 %b d2 %b mv %b%b exp d1 10 d2 00 mv 11",
                               sif.dir1, sif.dir2, sif.moving1, sif.moving2);
        end
        sif.keycode = 16'h1A16;
        tick();                         // E2 step
        checks++;
        if (sif.dir1 !== 2'b10 || sif.y_motion1 !== 10'h001 || sif.y_motion2 !== 10'h3FF) begin
            errors++; $display("FAIL dual_step got d1 %b y1 %h y2 %h exp d1 10 y1 001 y2 3ff",
                               sif.dir1, sif.y_motion1, sif.y_motion2);
        end
        do_reset();
        sif.keycode = 16'h4F04;         // snake1: lo 04 beats nothing-hi; snake2: hi 4F
        tick();
        checks++;
        if (sif.dir1 !== 2'b01 || sif.dir2 !== 2'b11) begin
            errors++; $display("FAIL byte_sel got d1 %b d2 %b exp d1 01 d2 11", sif.dir1, sif.dir2);
        end
        do_reset();
        sif.keycode = 16'h0704;         // lower byte (left) beats upper (right)
        tick();
        checks++;
        if (sif.dir1 !== 2'b01 || sif.moving2 !== 1'b0) begin
            errors++; $display("FAIL lo_priority got d1 %b mv2 %b exp d1 01 mv2 0", sif.dir1, sif.moving2);
        end
    endtask

    task automatic test_knock();
        do_reset();
        sif.keycode = 16'h0052;
        tick();                         // E1: snake2 MOVE up
        sif.keycode = 16'h0000;
        sif.hit2    = 1'b1;
        tick();                         // E2: enter KNOCK
        sif.keycode = 16'h0050;         // ignored during knock
        for (int f = 2; f <= 9; f++) begin
            checks++;
            if (sif.knock2 !== 1'b1 || sif.y_motion2 !== 10'h002 || sif.x_motion2 !== 10'h000 ||
                sif.dir2 !== 2'b00) begin
                errors++; $display("FAIL knock2 f%0d got k %b x %h y %h d %b exp k 1 x 000 y 002 d 00",
                                   f, sif.knock2, sif.x_motion2, sif.y_motion2, sif.dir2);
            end
            if (f < 9) tick();
        end
        sif.keycode = 16'h0000;
        tick();                         // E10: back to MOVE
        checks++;
        if (sif.knock2 !== 1'b0 || sif.moving2 !== 1'b1 || sif.dir2 !== 2'b00) begin
            errors++; $display("FAIL knock2_end got k %b mv %b d %b exp k 0 mv 1 d 00",
                               sif.knock2, sif.moving2, sif.dir2);
        end
        tick();                         // E11
        checks++;
        if (sif.knock2 !== 1'b0 || sif.y_motion2 !== 10'h000) begin
            errors++; $display("FAIL held_hit2_a got k %b y %h exp k 0 y 000", sif.knock2, sif.y_motion2);
        end
        tick();                         // E12 step
        checks++;
        if (sif.knock2 !== 1'b0 || sif.y_motion2 !== 10'h3FF || sif.moving1 !== 1'b0) begin
            errors++; $display("FAIL held_hit2_b got k %b y %h mv1 %b exp k 0 y 3ff mv1 0",
                               sif.knock2, sif.y_motion2, sif.moving1);
        end
        sif.hit2 = 1'b0;
    endtask

    task automatic test_knock_reload_run();
        logic       exp_k;
        logic [9:0] exp_x;
        do_reset();
        sif.keycode = 16'h0007;
        tick();                         // E1: MOVE right
        sif.keycode = 16'h0000;
        sif.hit1    = 1'b1;
        tick();                         // E2: KNOCK, cnt 7
        sif.hit1 = 1'b0;
        for (int e = 3; e <= 18; e++) begin
            if (e == 7)  sif.hit1 = 1'b1;   // knock frame 5: fresh edge reloads
            if (e == 8)  sif.hit1 = 1'b0;
            if (e == 10) sif.run  = 1'b0;
            if (e == 11) sif.hit1 = 1'b1;   // rises while frozen, tracked without effect
            if (e == 13) sif.run  = 1'b1;
            tick();
            exp_k = (e <= 17);
            exp_x = (e <= 17 && (e < 10 || e > 12)) ? 10'h3FE : 10'h000;
            checks++;
            if (sif.knock1 !== exp_k || sif.x_motion1 !== exp_x || sif.dir1 !== 2'b11) begin
                errors++; $display("FAIL reload_run E%0d got k %b x %h d %b exp k %b x %h d 11",
                                   e, sif.knock1, sif.x_motion1, sif.dir1, exp_k, exp_x);
            end
        end
        checks++;
        if (sif.moving1 !== 1'b1 || sif.y_motion1 !== 10'h000) begin
            errors++; $display("FAIL reload_end got mv %b y %h exp mv 1 y 000", sif.moving1, sif.y_motion1);
        end
        sif.hit1 = 1'b0;
    endtask

    task automatic test_reset_mid_knock();
        do_reset();
        sif.keycode = 16'h0007;
        tick();
        sif.keycode = 16'h0000;
        sif.hit1    = 1'b1;
        tick();
        tick();
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if ({sif.knock1, sif.moving1, sif.dir1} !== 4'h0 || sif.x_motion1 !== 10'h000) begin
            errors++; $display("FAIL async_reset got k %b mv %b d %b x %h exp all 0",
                               sif.knock1, sif.moving1, sif.dir1, sif.x_motion1);
        end
        sif.hit1 = 1'b0;
        Reset    = 1'b1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        Reset       = 1'b0;
        sif.run     = 1'b1;
        sif.keycode = 16'h0000;
        sif.hit1    = 1'b0;
        sif.hit2    = 1'b0;
        test_reset();
        test_move();
        test_reversal();
        test_dual_decode();
        test_knock();
        test_knock_reload_run();
        test_reset_mid_knock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
